// File: rtl/screen_arbiter.sv
`timescale 1ns/1ps
// Screen RAM owner: arbitrates LCD word prefetch (priority) against CPU accesses, serialises words to RGB565 pixels.
// CPU ack 3 clk after req is sampled in IDLE; a display fetch takes 2 clk; no backpressure to the LCD, late words raise sticky underrun.
module screen_arbiter #(
    parameter int          X_OFFSET = 144,
    parameter int          Y_OFFSET = 112,
    parameter logic [15:0] FG_COLOR = 16'hFFFF,
    parameter logic [15:0] BG_COLOR = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic [9:0]  h_pos,
    input  logic [9:0]  v_pos,
    output logic [15:0] pixel_rgb,
    output logic        underrun,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [12:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        ram_en,
    output logic        ram_we,
    output logic [12:0] ram_addr,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        D_ISSUE = 3'd1,
        D_CAPT  = 3'd2,
        C_ISSUE = 3'd3,
        C_CAPT  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        ram_en_q, ram_en_d;
    logic        ram_we_q, ram_we_d;
    logic [12:0] ram_addr_q, ram_addr_d;
    logic [15:0] ram_wdata_q, ram_wdata_d;
    logic        cpu_ack_q, cpu_ack_d;
    logic [15:0] cpu_rdata_q, cpu_rdata_d;
    logic [15:0] pf_q, pf_d;
    logic        pf_valid_q, pf_valid_d;
    logic [15:0] sh_q, sh_d;
    logic [12:0] fetch_ptr_q, fetch_ptr_d;
    logic [5:0]  words_left_q, words_left_d;
    logic        drop_q, drop_d;
    logic [15:0] pixel_q, pixel_d;
    logic        underrun_q, underrun_d;

    logic        fetch_need;
    logic        line_start;
    logic        in_x, in_y, in_win;
    logic [3:0]  bit_idx;
    logic [7:0]  row_idx;

    assign fetch_need = !pf_valid_q && (words_left_q != 6'd0);
    assign line_start = pix_en && (h_pos == 10'd0);
    assign in_x       = ({1'b0, h_pos} >= 11'(X_OFFSET)) && ({1'b0, h_pos} < 11'(X_OFFSET + 512));
    assign in_y       = ({1'b0, v_pos} >= 11'(Y_OFFSET)) && ({1'b0, v_pos} < 11'(Y_OFFSET + 256));
    assign in_win     = in_x && in_y;
    // Only the low bits of the window-relative offsets are ever needed, so modular subtraction suffices.
    assign bit_idx    = h_pos[3:0] - 4'(X_OFFSET);
    assign row_idx    = v_pos[7:0] - 8'(Y_OFFSET);

    always_comb begin
        state_d      = state_q;
        ram_en_d     = 1'b0;
        ram_we_d     = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        cpu_ack_d    = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        pf_d         = pf_q;
        pf_valid_d   = pf_valid_q;
        sh_d         = sh_q;
        fetch_ptr_d  = fetch_ptr_q;
        words_left_d = words_left_q;
        drop_d       = 1'b0;
        pixel_d      = pixel_q;
        underrun_d   = underrun_q;

        case (state_q)
            IDLE: begin
                if (fetch_need) begin
                    state_d    = D_ISSUE;
                    ram_en_d   = 1'b1;
                    ram_addr_d = fetch_ptr_q;
                end else if (cpu_req) begin
                    state_d     = C_ISSUE;
                    ram_en_d    = 1'b1;
                    ram_we_d    = cpu_we;
                    ram_addr_d  = cpu_addr;
                    ram_wdata_d = cpu_wdata;
                end
            end
            D_ISSUE: begin
                state_d = D_CAPT;
                // A line start while the read is in flight makes the returning word stale.
                drop_d  = line_start;
            end
            D_CAPT: begin
                state_d = IDLE;
                if (!drop_q) begin
                    pf_d         = ram_rdata;
                    pf_valid_d   = 1'b1;
                    fetch_ptr_d  = fetch_ptr_q + 13'd1;
                    words_left_d = words_left_q - 6'd1;
                end
            end
            C_ISSUE: begin
                state_d = C_CAPT;
            end
            C_CAPT: begin
                state_d     = IDLE;
                cpu_ack_d   = 1'b1;
                cpu_rdata_d = cpu_we ? 16'h0000 : ram_rdata;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (pix_en) begin
            if (in_win) begin
                if (bit_idx == 4'd0) begin
                    sh_d       = pf_q;
                    pf_valid_d = 1'b0;
                    if (!pf_valid_q) begin
                        underrun_d = 1'b1;
                        pixel_d    = BG_COLOR;
                    end else begin
                        pixel_d = pf_q[0] ? FG_COLOR : BG_COLOR;
                    end
                end else begin
                    pixel_d = sh_q[bit_idx] ? FG_COLOR : BG_COLOR;
                end
            end else begin
                pixel_d = BG_COLOR;
            end
        end

        // Line start overrides any word captured in the same cycle.
        if (line_start) begin
            pf_valid_d = 1'b0;
            if (in_y) begin
                fetch_ptr_d  = {row_idx, 5'd0};
                words_left_d = 6'd32;
            end else begin
                words_left_d = 6'd0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            ram_en_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            cpu_ack_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            pf_q         <= '0;
            pf_valid_q   <= 1'b0;
            sh_q         <= '0;
            fetch_ptr_q  <= '0;
            words_left_q <= '0;
            drop_q       <= 1'b0;
            pixel_q      <= '0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ram_en_q     <= ram_en_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            cpu_ack_q    <= cpu_ack_d;
            cpu_rdata_q  <= cpu_rdata_d;
            pf_q         <= pf_d;
            pf_valid_q   <= pf_valid_d;
            sh_q         <= sh_d;
            fetch_ptr_q  <= fetch_ptr_d;
            words_left_q <= words_left_d;
            drop_q       <= drop_d;
            pixel_q      <= pixel_d;
            underrun_q   <= underrun_d;
        end
    end

    assign pixel_rgb = pixel_q;
    assign underrun  = underrun_q;
    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_screen_arbiter.sv
`timescale 1ns/1ps
// Directed bench for screen_arbiter: CPU access timing, scanout pixels, window edges and underrun.
module tb_screen_arbiter;

    localparam int XO   = 144;
    localparam int YO   = 112;
    localparam int LINE = 660;

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_en;
    logic [9:0]  h_pos, v_pos;
    logic [15:0] pixel_rgb;
    logic        underrun;
    logic        cpu_req, cpu_we;
    logic [12:0] cpu_addr;
    logic [15:0] cpu_wdata, cpu_rdata;
    logic        cpu_ack;
    logic        ram_en, ram_we;
    logic [12:0] ram_addr;
    logic [15:0] ram_wdata, ram_rdata;

    logic        tb_wr;
    logic [12:0] tb_waddr;
    logic [15:0] tb_wdat;
    logic [15:0] mem    [8192];
    logic [15:0] shadow [8192];
    logic [15:0] line_px [LINE];
    int          ram_en_cnt = 0;
    int          errors = 0;
    int          checks = 0;
    logic        frame_done;

    screen_arbiter #(
        .X_OFFSET(XO), .Y_OFFSET(YO), .FG_COLOR(16'hFFFF), .BG_COLOR(16'h0000)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .h_pos(h_pos), .v_pos(v_pos),
        .pixel_rgb(pixel_rgb), .underrun(underrun),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM; the bench preloads it through a private write port.
    always @(posedge clk) begin
        if (tb_wr) begin
            mem[tb_waddr] <= tb_wdat;
        end else if (ram_en === 1'b1) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    always @(posedge clk) begin
        if (ram_en === 1'b1) ram_en_cnt <= ram_en_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pat(input int i);
        return 16'(i * 40503) ^ 16'h5A3C;
    endfunction

    task automatic poke(input int a, input logic [15:0] d);
        tb_wr    = 1'b1;
        tb_waddr = 13'(a);
        tb_wdat  = d;
        shadow[a] = d;
        tick();
        tb_wr = 1'b0;
    endtask

    function automatic logic [15:0] exp_px(input int v, input int h);
        logic [15:0] w;
        if (v >= YO && v < YO + 256 && h >= XO && h < XO + 512) begin
            w = shadow[(v - YO) * 32 + (h - XO) / 16];
            return w[(h - XO) % 16] ? 16'hFFFF : 16'h0000;
        end
        return 16'h0000;
    endfunction

    task automatic scan_row(input int v, output int bad);
        bad = 0;
        for (int h = 0; h < LINE; h++) begin
            pix_en = 1'b1;
            h_pos  = 10'(h);
            v_pos  = 10'(v);
            tick();
            line_px[h] = pixel_rgb;
            if (pixel_rgb !== exp_px(v, h)) bad++;
        end
        pix_en = 1'b0;
    endtask

    task automatic cpu_access(input logic we, input int a, input logic [15:0] wd,
                              output logic [15:0] rd, output int lat);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = 13'(a);
        cpu_wdata = wd;
        lat = 0;
        rd  = 16'hDEAD;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (cpu_ack === 1'b1) begin
                lat = n;
                rd  = cpu_rdata;
                break;
            end
        end
        cpu_req = 1'b0;
        if (we && lat != 0) shadow[a] = wd;
    endtask

    initial begin
        logic [15:0] rd;
        int          lat, bad, e0, nz, acc;
        int          rows [16];

        reset = 1'b1; pix_en = 1'b0; h_pos = '0; v_pos = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        tb_wr = 1'b0; tb_waddr = '0; tb_wdat = '0; frame_done = 1'b0;
        tick();
        for (int i = 0; i < 8192; i++) poke(i, pat(i));

        check("rst_pixel",    32'(pixel_rgb), 0);
        check("rst_underrun", 32'(underrun),  0);
        check("rst_ack",      32'(cpu_ack),   0);
        check("rst_rdata",    32'(cpu_rdata), 0);
        check("rst_ram_en",   32'(ram_en),    0);
        check("rst_ram_we",   32'(ram_we),    0);
        check("rst_ram_addr", 32'(ram_addr),  0);
        check("rst_ram_wdat", 32'(ram_wdata), 0);

        reset = 1'b0;
        e0 = ram_en_cnt;
        repeat (10) tick();
        check("idle_no_ram_en", 32'(ram_en_cnt - e0), 0);

        cpu_access(1'b1, 5, 16'hA5A5, rd, lat);
        check("wr_latency", 32'(lat), 3);
        check("wr_rdata",   32'(rd),  0);
        tick();
        check("ack_one_cycle", 32'(cpu_ack), 0);
        cpu_access(1'b0, 5, 16'h0000, rd, lat);
        check("rd_latency", 32'(lat), 3);
        check("rd_data",    32'(rd),  32'h0000A5A5);

        // Reset in C_ISSUE: the write to word 7 must never happen and no ack may follow.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'd7; cpu_wdata = 16'h1234;
        tick();
        check("c_issue_en", 32'(ram_en), 1);
        reset = 1'b1;
        #1;
        check("rst_drops_en", 32'(ram_en), 0);
        cpu_req = 1'b0;
        tick();
        reset = 1'b0;
        acc = 0;
        repeat (6) begin
            tick();
            if (cpu_ack === 1'b1) acc++;
        end
        check("no_ack_after_rst", 32'(acc), 0);
        cpu_access(1'b0, 7, 16'h0000, rd, lat);
        check("word7_unwritten", 32'(rd), 32'(pat(7)));

        poke(0, 16'h0001);
        poke(1, 16'h8000);
        poke(31, 16'hFFFF);
        scan_row(YO, bad);
        check("row112_x143", 32'(line_px[143]), 0);
        check("row112_x144", 32'(line_px[144]), 32'h0000FFFF);
        nz = 0;
        for (int x = 145; x <= 174; x++) if (line_px[x] !== 16'h0000) nz++;
        check("row112_x145_174", 32'(nz), 0);
        check("row112_x175", 32'(line_px[175]), 32'h0000FFFF);
        check("row112_x655", 32'(line_px[655]), 32'h0000FFFF);
        check("row112_x656", 32'(line_px[656]), 0);
        check("row112_model", 32'(bad), 0);
        check("row112_underrun", 32'(underrun), 0);

        for (int i = 0; i < 8; i++) begin
            rows[i]     = YO + i;
            rows[i + 8] = YO + 248 + i;
        end
        fork
            begin
                int b;
                foreach (rows[i]) begin
                    scan_row(rows[i], b);
                    check("frame_row", 32'(b), 0);
                end
                frame_done = 1'b1;
            end
            begin
                int          k, n;
                logic [15:0] expd;
                k = 0;
                cpu_req = 1'b1;
                while (!frame_done) begin
                    cpu_we    = k[0];
                    cpu_addr  = k[0] ? 13'(3000 + k % 1000) : 13'($urandom_range(8191));
                    cpu_wdata = 16'($urandom);
                    expd      = shadow[cpu_addr];
                    n = 0;
                    for (int c = 1; c <= 8; c++) begin
                        tick();
                        if (cpu_ack === 1'b1) begin
                            n = c;
                            break;
                        end
                    end
                    check("ack_within_6", 32'(n >= 3 && n <= 6), 1);
                    if (n == 0) break;
                    if (cpu_we) shadow[cpu_addr] = cpu_wdata;
                    else check("frame_rdata", 32'(cpu_rdata), 32'(expd));
                    k++;
                end
                cpu_req = 1'b0;
            end
        join
        check("frame_underrun", 32'(underrun), 0);

        repeat (4) tick();
        e0 = ram_en_cnt;
        scan_row(50, bad);
        check("row50_no_fetch", 32'(ram_en_cnt - e0), 0);
        nz = 0;
        for (int x = 0; x < LINE; x++) if (line_px[x] !== 16'h0000) nz++;
        check("row50_all_bg", 32'(nz), 0);
        check("row50_underrun", 32'(underrun), 0);

        // Jump straight from line start to the first window column so the word cannot be ready.
        pix_en = 1'b1; v_pos = 10'(YO); h_pos = 10'd0;
        tick();
        h_pos = 10'(XO);
        tick();
        pix_en = 1'b0;
        check("underrun_set", 32'(underrun),  1);
        check("underrun_bg",  32'(pixel_rgb), 0);
        repeat (20) tick();
        check("underrun_sticky", 32'(underrun),  1);
        check("pixel_holds",     32'(pixel_rgb), 0);
        reset = 1'b1;
        #1;
        check("underrun_rst", 32'(underrun), 0);
        tick();
        reset = 1'b0;
        tick();
        check("underrun_after_rst", 32'(underrun), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/screen_arbiter.md
Name: screen_arbiter

Overview:
Owns the single-port 8K x 16 Hack screen RAM (512x256, 1 bpp). It arbitrates between two requesters: CPU memory-mapped screen accesses, and the LCD scanout word prefetch, which has priority. It converts fetched words into 16-bit RGB565 pixels aligned to the rgb_lcd h_pos/v_pos counters. It sits between computer and rgb_lcd in top, replacing the constant-black lcd_rgb_data drive.

Parameters:
X_OFFSET, 144, first active LCD column of the 512-wide window (must be >= 1)
Y_OFFSET, 112, first active LCD row of the 256-high window
FG_COLOR, 16'hFFFF, RGB565 colour for bit=1
BG_COLOR, 16'h0000, RGB565 colour for bit=0 and for pixels outside the window

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
pix_en  in  1  one-clk strobe per LCD pixel; h_pos/v_pos valid when high
h_pos  in  10  current LCD column
v_pos  in  10  current LCD row
pixel_rgb  out  16  registered RGB565 pixel
underrun  out  1  sticky: a word was needed before its prefetch completed
cpu_req  in  1  CPU access request; held with stable fields until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  13  screen word address (row*32 + col/16)
cpu_wdata  in  16  write data
cpu_rdata  out  16  read data, valid while cpu_ack=1
cpu_ack  out  1  one-cycle completion pulse
ram_en  out  1  RAM enable (registered)
ram_we  out  1  RAM write enable (registered)
ram_addr  out  13  RAM address (registered)
ram_wdata  out  16  RAM write data (registered)
ram_rdata  in  16  synchronous RAM read data, valid the cycle after ram_en

Behaviour:
- Reset (async): all outputs 0; FSM=IDLE; prefetch/shift registers invalid; underrun=0; any in-flight CPU access is dropped with no ack.
- FSM states: IDLE, D_ISSUE, D_CAPT, C_ISSUE, C_CAPT.
- IDLE:
  - If a display fetch is needed: go to D_ISSUE.
  - Else if cpu_req=1: go to C_ISSUE.
  - Display wins on simultaneous requests.
- D_ISSUE: ram_en=1, ram_we=0, ram_addr=fetch_ptr. Go to D_CAPT.
- D_CAPT: pf <= ram_rdata, pf_valid <= 1, fetch_ptr++, words_left--. Go to IDLE.
- C_ISSUE: drive ram_en=1, ram_we=cpu_we, ram_addr=cpu_addr, ram_wdata=cpu_wdata. Go to C_CAPT.
- C_CAPT:
  - Register cpu_rdata <= ram_rdata (write: cpu_rdata=0) and cpu_ack <= 1.
  - Go to IDLE.
  - cpu_ack is therefore high exactly 1 cycle, 3 cycles after cpu_req was sampled in IDLE.
  - cpu_req still high during the ack cycle counts as a new request.
- Display fetch needed ⇔ pf_valid=0 and words_left>0.
- Line start, on pix_en with h_pos=0:
  - If Y_OFFSET <= v_pos < Y_OFFSET+256: fetch_ptr <= (v_pos-Y_OFFSET)*32, words_left <= 32, pf_valid <= 0.
  - Else: words_left <= 0, so no fetches occur on that line.
  - If this coincides with D_CAPT, the captured data is discarded.
- Pixel path (on pix_en; x_rel = h_pos-X_OFFSET, y in window):
  - Inside the window with x_rel%16 = 0: sh <= pf, pf_valid <= 0; pixel bit = pf[0]. If pf_valid=0, set underrun=1 and output BG_COLOR.
  - Inside the window otherwise: pixel bit = sh[x_rel%16] (bit 0 = leftmost pixel).
  - pixel_rgb <= bit ? FG_COLOR : BG_COLOR.
  - Outside the window: pixel_rgb <= BG_COLOR.
  - Latency: pixel_rgb updates the clk after the pix_en sample; it holds between strobes.
- Budget: a display fetch needs <=5 clk (an in-progress CPU access plus 3). 16 pix_en occur per word, so underrun cannot occur for any pix_en rate <= 1 per clk.
- CPU write to a word already prefetched: visible from the next frame; no coherence requirement.
- underrun clears only on reset.
- Addresses wrap modulo 8192; fetch_ptr never exceeds row*32+31.

Test Plan:
- Reset held, then released → all outputs 0, ram_en stays 0 with no pix_en and no cpu_req; pulse reset mid-C_ISSUE → ram_en drops same cycle, no cpu_ack.
- CPU write 0x0005 ← 16'hA5A5, then read 0x0005 → each cpu_ack arrives 3 cycles after req sampled; read returns cpu_rdata=16'hA5A5.
- RAM word 0 = 16'h0001, word 1 = 16'h8000; scan row Y_OFFSET with pix_en every clk → pixel_rgb = FFFF at x=144, 0000 at x=145..174, FFFF at x=175; underrun=0.
- cpu_req held high continuously through a full frame → underrun=0, every cpu_ack within 6 cycles of its request, display words bit-exact vs. model.
- Row v_pos=50 (outside window) → zero ram_en pulses on that line; pixel_rgb=BG for all x. Pixels at x=143 and x=656 on in-window rows also = BG.
- Force underrun by stalling (hold cpu_req, pix_en every clk, modified FSM via X_OFFSET=1 and line start at h_pos=0) → if pf not ready at x_rel=0: underrun=1 sticky, pixel=BG; cleared only by reset.
